voice_scheduler: RTL and testbench
==================================

# voice_scheduler

Allocates the synth's 8 oscillator voices from parsed MIDI note events. It accepts one note-on/note-off event at a time over a valid/ready handshake and scans the voice table sequentially. It then assigns, retriggers, steals or releases a voice, and drives the per-voice on/note/velocity bus consumed by the oscillator bank. It sits between the MIDI byte parser and the voice datapath, replacing ad-hoc first-free allocation with a defined policy: retrigger-same-note, else lowest free, else steal oldest.

## Interface
- NUM_VOICES, 8, number of voices; power of two, 2..16
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ev_valid  in  1  event offered
- ev_ready  out  1  scheduler can accept an event
- ev_on  in  1  1 = note-on, 0 = note-off
- ev_note  in  7  MIDI note number
- ev_vel  in  7  MIDI velocity
- all_off  in  1  panic: release every voice
- on_out  out  NUM_VOICES  voice active flags
- note_out  out  NUM_VOICES x 7  note per voice
- velocity_out  out  NUM_VOICES x 3  velocity per voice (ev_vel[6:4])
- trig_out  out  NUM_VOICES  one-cycle pulse when a voice is (re)assigned
- busy  out  1  FSM not in IDLE

## Operation
- State per voice: on, note, velocity, age (log2(NUM_VOICES) bits, saturating at NUM_VOICES-1).
- FSM states:
  - IDLE: ev_ready=1. Handshake completes on an edge with ev_valid && ev_ready. At that edge, latch ev_on/ev_note/ev_vel, clear the scan index and results, and go to SCAN.
  - SCAN: ev_ready=0. Examine voice i = 0..NUM_VOICES-1, one per cycle. Track:
    - match_idx: lowest i with on && note==ev_note
    - free_idx: lowest i with !on
    - old_idx: active voice with maximum age, ties resolved to the lowest index
  - SCAN → APPLY after index NUM_VOICES-1 is examined.
  - APPLY: one cycle, then → IDLE.
- A note-on with ev_vel==0 is treated as note-off (MIDI running-status convention).
- Note-on target voice, in priority order: match_idx, else free_idx, else old_idx (steal). On the target voice:
  - on←1, note←ev_note, velocity←ev_vel[6:4], age←0, trig pulse.
  - Every other active voice: age←age+1, saturating.
- Note-off:
  - Every voice with on && note==ev_note: on←0, age←0.
  - Other voices are unchanged. If no voice matches, nothing changes and there is no trig.
- Off voices keep their last note/velocity values; only on_out is cleared.
- all_off has priority over everything, in any state:
  - At that edge, on_out←0 and all ages←0.
  - Any event in SCAN/APPLY is discarded and the FSM goes to IDLE.
  - trig_out←0.
  - ev_ready is 1 in the following cycle.
  - If all_off is high in IDLE together with a handshake, the event is dropped: all_off wins and nothing is latched.

## Timing
- Reset: state IDLE; ev_ready=1; busy=0; on_out=0; note_out=0; velocity_out=0; trig_out=0; all ages=0; scan registers=0.
- Accept on edge E0. SCAN occupies cycles E0..E0+NUM_VOICES-1, APPLY occupies cycle E0+NUM_VOICES, and the voice bus updates at edge E0+NUM_VOICES+1. Latency is therefore NUM_VOICES+1 edges (9 for 8 voices).
- trig_out is high for exactly the one cycle following the update edge.
- ev_ready is high again in the cycle after APPLY. Maximum rate is one event per NUM_VOICES+2 cycles.
- Voice-bus outputs are registered with no combinational path from inputs. ev_ready and busy are decoded directly from state.
- ev_note/ev_vel are ignored outside the handshake edge, so the upstream may change them freely while ev_ready=0.

## Test plan
- Reset → all outputs at reset values and ev_ready=1. Then note-on note 60 vel 100 accepted at edge E0 → at edge E0+9: on_out=8'h01, note_out[0]=60, velocity_out[0]=6. trig_out[0] high for one cycle; ev_ready high again.
- Note-ons for notes 60..67 fill voices 0..7. A 9th note-on, note 70, steals voice 0 (age 7): note_out[0]=70, trig_out=8'h01, on_out stays 8'hFF.
- Note 60 active on voice 0, then note-on 60 vel 127 → retrigger voice 0 only: velocity_out[0]=7, trig_out[0] pulses, no second voice allocated.
- Notes 60 and 62 active, then note-off 60 → on_out[0]=0 and on_out[1]=1. Then note-on 64 vel 0 → no change and no trig. Then note-on 64 vel 80 → lands in voice 0.
- all_off asserted during SCAN cycle 3 of a pending note-on → next cycle on_out=0, no trig, ev_ready=1. The pending event never applies.
- ev_valid held high with back-to-back events → exactly one accept per 10 cycles. ev_ready is low for the whole SCAN/APPLY window.

Source files
------------

// File: rtl/voice_scheduler.sv
// Voice allocator: retrigger same note, else lowest free voice, else steal the oldest active voice.
// Latency: the voice bus updates NUM_VOICES+1 edges after the accept edge; trig_out pulses for one cycle.
// Backpressure: ev_ready is high only in IDLE, so at most one event is accepted every NUM_VOICES+2 cycles.
module voice_scheduler #(
  parameter int NUM_VOICES = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ev_valid,
  output logic                         ev_ready,
  input  logic                         ev_on,
  input  logic [6:0]                   ev_note,
  input  logic [6:0]                   ev_vel,
  input  logic                         all_off,
  output logic [NUM_VOICES-1:0]        on_out,
  output logic [NUM_VOICES-1:0][6:0]   note_out,
  output logic [NUM_VOICES-1:0][2:0]   velocity_out,
  output logic [NUM_VOICES-1:0]        trig_out,
  output logic                         busy
);

  localparam int IW = $clog2(NUM_VOICES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_VOICES - 1);
  localparam logic [IW-1:0] AGE_MAX  = IW'(NUM_VOICES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_APPLY = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Latched event; ev_on_q already folds velocity 0 into note-off
  logic          ev_on_q,   ev_on_d;
  logic [6:0]    ev_note_q, ev_note_d;
  logic [2:0]    ev_vel_q,  ev_vel_d;

  // Scan position and results
  logic [IW-1:0]         scan_idx_q,   scan_idx_d;
  logic [NUM_VOICES-1:0] match_mask_q, match_mask_d;
  logic                  match_vld_q,  match_vld_d;
  logic [IW-1:0]         match_idx_q,  match_idx_d;
  logic                  free_vld_q,   free_vld_d;
  logic [IW-1:0]         free_idx_q,   free_idx_d;
  logic                  old_vld_q,    old_vld_d;
  logic [IW-1:0]         old_idx_q,    old_idx_d;
  logic [IW-1:0]         old_age_q,    old_age_d;

  // Voice table
  logic [NUM_VOICES-1:0]          on_q,   on_d;
  logic [NUM_VOICES-1:0][6:0]     note_q, note_d;
  logic [NUM_VOICES-1:0][2:0]     vel_q,  vel_d;
  logic [NUM_VOICES-1:0][IW-1:0]  age_q,  age_d;
  logic [NUM_VOICES-1:0]          trig_q, trig_d;

  logic          accept;
  logic [IW-1:0] target_idx;

  assign accept = ev_valid && (state_q == S_IDLE) && !all_off;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; all_off returns to IDLE from anywhere
  always_comb begin
    state_d = state_q;
    if (all_off) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (ev_valid) state_d = S_SCAN;
        S_SCAN:  if (scan_idx_q == LAST_IDX) state_d = S_APPLY;
        S_APPLY: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Handshake and status decoded straight from state
  always_comb begin
    ev_ready = (state_q == S_IDLE);
    busy     = (state_q != S_IDLE);
  end

  // Event latch and sequential scan of one voice per cycle
  always_comb begin
    ev_on_d      = ev_on_q;
    ev_note_d    = ev_note_q;
    ev_vel_d     = ev_vel_q;
    scan_idx_d   = scan_idx_q;
    match_mask_d = match_mask_q;
    match_vld_d  = match_vld_q;
    match_idx_d  = match_idx_q;
    free_vld_d   = free_vld_q;
    free_idx_d   = free_idx_q;
    old_vld_d    = old_vld_q;
    old_idx_d    = old_idx_q;
    old_age_d    = old_age_q;
    if (accept) begin
      ev_on_d      = ev_on && (ev_vel != 7'd0);
      ev_note_d    = ev_note;
      ev_vel_d     = ev_vel[6:4];
      scan_idx_d   = '0;
      match_mask_d = '0;
      match_vld_d  = 1'b0;
      match_idx_d  = '0;
      free_vld_d   = 1'b0;
      free_idx_d   = '0;
      old_vld_d    = 1'b0;
      old_idx_d    = '0;
      old_age_d    = '0;
    end else if (state_q == S_SCAN && !all_off) begin
      scan_idx_d = scan_idx_q + IW'(1);
      if (on_q[scan_idx_q]) begin
        if (note_q[scan_idx_q] == ev_note_q) begin
          match_mask_d[scan_idx_q] = 1'b1;
          if (!match_vld_q) begin
            match_vld_d = 1'b1;
            match_idx_d = scan_idx_q;
          end
        end
        // Strictly greater keeps the lowest index on equal ages
        if (!old_vld_q || (age_q[scan_idx_q] > old_age_q)) begin
          old_vld_d = 1'b1;
          old_idx_d = scan_idx_q;
          old_age_d = age_q[scan_idx_q];
        end
      end else if (!free_vld_q) begin
        free_vld_d = 1'b1;
        free_idx_d = scan_idx_q;
      end
    end
  end

  // Note-on target: retrigger, else lowest free, else steal oldest
  always_comb begin
    if (match_vld_q) begin
      target_idx = match_idx_q;
    end else if (free_vld_q) begin
      target_idx = free_idx_q;
    end else begin
      target_idx = old_idx_q;
    end
  end

  // Voice table update in APPLY; all_off clears on flags and ages
  always_comb begin
    on_d   = on_q;
    note_d = note_q;
    vel_d  = vel_q;
    age_d  = age_q;
    trig_d = '0;
    if (all_off) begin
      on_d  = '0;
      age_d = '0;
    end else if (state_q == S_APPLY) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (ev_on_q) begin
          if (IW'(v) == target_idx) begin
            on_d[v]   = 1'b1;
            note_d[v] = ev_note_q;
            vel_d[v]  = ev_vel_q;
            age_d[v]  = '0;
            trig_d[v] = 1'b1;
          end else if (on_q[v] && (age_q[v] != AGE_MAX)) begin
            age_d[v] = age_q[v] + IW'(1);
          end
        end else if (match_mask_q[v]) begin
          on_d[v]  = 1'b0;
          age_d[v] = '0;
        end
      end
    end
  end

  // Datapath and voice-table registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ev_on_q      <= 1'b0;
      ev_note_q    <= '0;
      ev_vel_q     <= '0;
      scan_idx_q   <= '0;
      match_mask_q <= '0;
      match_vld_q  <= 1'b0;
      match_idx_q  <= '0;
      free_vld_q   <= 1'b0;
      free_idx_q   <= '0;
      old_vld_q    <= 1'b0;
      old_idx_q    <= '0;
      old_age_q    <= '0;
      on_q         <= '0;
      note_q       <= '0;
      vel_q        <= '0;
      age_q        <= '0;
      trig_q       <= '0;
    end else begin
      ev_on_q      <= ev_on_d;
      ev_note_q    <= ev_note_d;
      ev_vel_q     <= ev_vel_d;
      scan_idx_q   <= scan_idx_d;
      match_mask_q <= match_mask_d;
      match_vld_q  <= match_vld_d;
      match_idx_q  <= match_idx_d;
      free_vld_q   <= free_vld_d;
      free_idx_q   <= free_idx_d;
      old_vld_q    <= old_vld_d;
      old_idx_q    <= old_idx_d;
      old_age_q    <= old_age_d;
      on_q         <= on_d;
      note_q       <= note_d;
      vel_q        <= vel_d;
      age_q        <= age_d;
      trig_q       <= trig_d;
    end
  end

  assign on_out       = on_q;
  assign note_out     = note_q;
  assign velocity_out = vel_q;
  assign trig_out     = trig_q;

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler: table of note events with expected voice-bus state,
// followed by hand-written sequences for all_off aborts, dropped handshakes and back-to-back rate.
module tb_voice_scheduler;

  logic            clk = 1'b0;
  logic            rst;
  logic            ev_valid;
  logic            ev_ready;
  logic            ev_on;
  logic [6:0]      ev_note;
  logic [6:0]      ev_vel;
  logic            all_off;
  logic [7:0]      on_out;
  logic [7:0][6:0] note_out;
  logic [7:0][2:0] velocity_out;
  logic [7:0]      trig_out;
  logic            busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       on;
    logic [6:0] note;
    logic [6:0] vel;
    int         idx;
    logic [7:0] exp_on;
    logic [7:0] exp_trig;
    logic [6:0] exp_note;
    logic [2:0] exp_vel;
  } vec_t;

  vec_t vecs[18];

  voice_scheduler #(.NUM_VOICES(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_on        (ev_on),
    .ev_note      (ev_note),
    .ev_vel       (ev_vel),
    .all_off      (all_off),
    .on_out       (on_out),
    .note_out     (note_out),
    .velocity_out (velocity_out),
    .trig_out     (trig_out),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ev_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_send", {31'd0, ev_ready}, 32'd1);
  endtask

  // Offers one event at a negedge; returns at the negedge just after the update edge E0+9
  task automatic send(input logic on, input logic [6:0] note, input logic [6:0] vel);
    int bad = 0;
    wait_ready();
    ev_on    = on;
    ev_note  = note;
    ev_vel   = vel;
    ev_valid = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i == 0) ev_valid = 1'b0;
      ev_on   = 1'($urandom);
      ev_note = 7'($urandom);
      ev_vel  = 7'($urandom);
      if (ev_ready || !busy) bad++;
    end
    @(negedge clk);
    chk("busy_window", bad, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int trig_seen;
    int n_acc;
    int last_k;
    int gap_bad;

    // on, note, vel, voice, on_out, trig_out, note_out[voice], velocity_out[voice]
    vecs[0]  = '{1'b1, 7'd60, 7'd100, 0, 8'h01, 8'h01, 7'd60, 3'd6};
    vecs[1]  = '{1'b1, 7'd61, 7'd64,  1, 8'h03, 8'h02, 7'd61, 3'd4};
    vecs[2]  = '{1'b1, 7'd62, 7'd64,  2, 8'h07, 8'h04, 7'd62, 3'd4};
    vecs[3]  = '{1'b1, 7'd63, 7'd64,  3, 8'h0F, 8'h08, 7'd63, 3'd4};
    vecs[4]  = '{1'b1, 7'd64, 7'd64,  4, 8'h1F, 8'h10, 7'd64, 3'd4};
    vecs[5]  = '{1'b1, 7'd65, 7'd64,  5, 8'h3F, 8'h20, 7'd65, 3'd4};
    vecs[6]  = '{1'b1, 7'd66, 7'd64,  6, 8'h7F, 8'h40, 7'd66, 3'd4};
    vecs[7]  = '{1'b1, 7'd67, 7'd64,  7, 8'hFF, 8'h80, 7'd67, 3'd4};
    vecs[8]  = '{1'b1, 7'd70, 7'd32,  0, 8'hFF, 8'h01, 7'd70, 3'd2};  // steal voice 0 (age 7)
    vecs[9]  = '{1'b1, 7'd62, 7'd127, 2, 8'hFF, 8'h04, 7'd62, 3'd7};  // retrigger voice 2
    vecs[10] = '{1'b0, 7'd63, 7'd0,   3, 8'hF7, 8'h00, 7'd63, 3'd4};  // note-off keeps note/vel
    vecs[11] = '{1'b1, 7'd64, 7'd0,   4, 8'hE7, 8'h00, 7'd64, 3'd4};  // vel 0 acts as off
    vecs[12] = '{1'b1, 7'd80, 7'd80,  3, 8'hEF, 8'h08, 7'd80, 3'd5};  // lowest free
    vecs[13] = '{1'b1, 7'd90, 7'd0,   3, 8'hEF, 8'h00, 7'd80, 3'd5};  // vel 0, no match
    vecs[14] = '{1'b0, 7'd99, 7'd0,   3, 8'hEF, 8'h00, 7'd80, 3'd5};  // off, no match
    vecs[15] = '{1'b1, 7'd81, 7'd16,  4, 8'hFF, 8'h10, 7'd81, 3'd1};
    vecs[16] = '{1'b1, 7'd82, 7'd112, 1, 8'hFF, 8'h02, 7'd82, 3'd7};  // steal voice 1 (saturated)
    vecs[17] = '{1'b1, 7'd83, 7'd100, 5, 8'hFF, 8'h20, 7'd83, 3'd6};  // steal voice 5

    rst      = 1'b1;
    ev_valid = 1'b0;
    ev_on    = 1'b0;
    ev_note  = '0;
    ev_vel   = '0;
    all_off  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("reset_ready", {31'd0, ev_ready}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_on", {24'd0, on_out}, 32'd0);
    chk("reset_note", note_out[1:0], 32'd0);
    chk("reset_note_hi", note_out[7:6], 32'd0);
    chk("reset_vel", {8'd0, velocity_out}, 32'd0);
    chk("reset_trig", {24'd0, trig_out}, 32'd0);

    for (int i = 0; i < 18; i++) begin
      send(vecs[i].on, vecs[i].note, vecs[i].vel);
      chk($sformatf("v%0d_on", i), {24'd0, on_out}, {24'd0, vecs[i].exp_on});
      chk($sformatf("v%0d_trig", i), {24'd0, trig_out}, {24'd0, vecs[i].exp_trig});
      chk($sformatf("v%0d_note", i), {25'd0, note_out[vecs[i].idx]}, {25'd0, vecs[i].exp_note});
      chk($sformatf("v%0d_vel", i), {29'd0, velocity_out[vecs[i].idx]}, {29'd0, vecs[i].exp_vel});
      chk($sformatf("v%0d_ready", i), {31'd0, ev_ready}, 32'd1);
      @(negedge clk);
      chk($sformatf("v%0d_trig_end", i), {24'd0, trig_out}, 32'd0);
    end

    // all_off during SCAN index 3 discards the pending note-on
    wait_ready();
    ev_on    = 1'b1;
    ev_note  = 7'd90;
    ev_vel   = 7'd100;
    ev_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ev_valid = 1'b0;
    repeat (3) @(negedge clk);
    all_off = 1'b1;
    @(negedge clk);
    all_off = 1'b0;
    chk("abort_on", {24'd0, on_out}, 32'd0);
    chk("abort_trig", {24'd0, trig_out}, 32'd0);
    chk("abort_ready", {31'd0, ev_ready}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_keep_note", {25'd0, note_out[0]}, 32'd70);
    chk("abort_keep_vel", {29'd0, velocity_out[0]}, 32'd2);
    trig_seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (trig_out != 8'h00) trig_seen++;
    end
    chk("abort_no_trig", trig_seen, 0);
    chk("abort_on_later", {24'd0, on_out}, 32'd0);

    // all_off together with a handshake in IDLE: event dropped
    ev_on    = 1'b1;
    ev_note  = 7'd55;
    ev_vel   = 7'd100;
    ev_valid = 1'b1;
    all_off  = 1'b1;
    @(negedge clk);
    ev_valid = 1'b0;
    all_off  = 1'b0;
    chk("drop_ready", {31'd0, ev_ready}, 32'd1);
    chk("drop_busy", {31'd0, busy}, 32'd0);
    trig_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (trig_out != 8'h00) trig_seen++;
    end
    chk("drop_no_trig", trig_seen, 0);
    chk("drop_on", {24'd0, on_out}, 32'd0);

    // After panic every voice is free again: lowest free is voice 0
    send(1'b1, 7'd60, 7'd100);
    chk("post_on", {24'd0, on_out}, 32'h01);
    chk("post_trig", {24'd0, trig_out}, 32'h01);
    chk("post_note", {25'd0, note_out[0]}, 32'd60);

    // Back-to-back: ev_valid held high for 40 cycles
    @(negedge clk);
    n_acc   = 0;
    last_k  = 0;
    gap_bad = 0;
    ev_on   = 1'b1;
    ev_vel  = 7'd100;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      ev_valid = 1'b1;
      if (ev_ready) begin
        ev_note = 7'(100 + n_acc);
        if (n_acc > 0 && (k - last_k) != 10) gap_bad++;
        last_k = k;
        n_acc++;
      end else begin
        ev_note = 7'($urandom);
      end
    end
    @(negedge clk);
    ev_valid = 1'b0;
    chk("b2b_accepts", n_acc, 4);
    chk("b2b_spacing", gap_bad, 0);
    repeat (12) @(negedge clk);
    chk("b2b_on", {24'd0, on_out}, 32'h1F);
    chk("b2b_note1", {25'd0, note_out[1]}, 32'd100);
    chk("b2b_note4", {25'd0, note_out[4]}, 32'd103);
    chk("b2b_vel4", {29'd0, velocity_out[4]}, 32'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
